// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between execute and the divider
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      flush;
    logic                      div_start;
    logic                      div_signed;
    logic [DATA_WIDTH-1:0]     div_data1;
    logic [DATA_WIDTH-1:0]     div_data2;
    logic [2*DATA_WIDTH-1:0]   div_result;
    logic                      div_done;

    modport master (
        output flush, div_start, div_signed, div_data1, div_data2,
        input  div_result, div_done
    );

    modport slave (
        input  flush, div_start, div_signed, div_data1, div_data2,
        output div_result, div_done
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider returning {remainder, quotient}
// Optional feature: define DIV_EARLY_OUT_EN to finish divide-by-zero and
// |dividend| < |divisor| requests without iterating.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                    r_state;
    logic [DATA_WIDTH-1:0]     r_rem;
    logic [DATA_WIDTH-1:0]     r_dvd;
    logic [DATA_WIDTH-1:0]     r_dvs;
    logic [CW-1:0]             r_cnt;
    logic                      r_qsign;
    logic                      r_rsign;
    logic                      r_done;
    logic [2*DATA_WIDTH-1:0]   r_result;

    logic                      w_sign1;
    logic                      w_sign2;
    logic [DATA_WIDTH-1:0]     w_abs1;
    logic [DATA_WIDTH-1:0]     w_abs2;
    logic                      w_div0;
    logic                      w_early;
    logic [DATA_WIDTH:0]       w_shift;
    logic [DATA_WIDTH:0]       w_trial;
    logic [DATA_WIDTH-1:0]     w_quo_fix;
    logic [DATA_WIDTH-1:0]     w_rem_fix;

    assign w_sign1   = bus.div_signed & bus.div_data1[DATA_WIDTH-1];
    assign w_sign2   = bus.div_signed & bus.div_data2[DATA_WIDTH-1];
    assign w_abs1    = w_sign1 ? -bus.div_data1 : bus.div_data1;
    assign w_abs2    = w_sign2 ? -bus.div_data2 : bus.div_data2;
    assign w_div0    = (bus.div_data2 == '0);
    assign w_shift   = {r_rem, r_dvd[DATA_WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_quo_fix = r_qsign ? -r_dvd : r_dvd;
    assign w_rem_fix = r_rsign ? -r_rem : r_rem;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = w_div0 | (w_abs1 < w_abs2);
`else
    assign w_early = 1'b0;
`endif

    assign bus.div_result = r_result;
    assign bus.div_done   = r_done;

    // Control FSM and datapath: latch magnitudes, iterate, fix signs, pulse done.
    // A zero divisor keeps the quotient unsigned so it stays all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.div_start) begin
                        r_cnt <= '0;
                        if (w_early) begin
                            r_rem   <= bus.div_data1;
                            r_dvd   <= {DATA_WIDTH{w_div0}};
                            r_qsign <= 1'b0;
                            r_rsign <= 1'b0;
                            r_state <= FIX;
                        end else begin
                            r_rem   <= '0;
                            r_dvd   <= w_abs1;
                            r_dvs   <= w_abs2;
                            r_qsign <= (w_sign1 ^ w_sign2) & ~w_div0;
                            r_rsign <= w_sign1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!bus.div_start) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem   <= w_trial[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
                        r_dvd   <= {r_dvd[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH]};
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= (r_cnt == CW'(DATA_WIDTH - 1)) ? FIX : CALC;
                    end
                end
                FIX: begin
                    if (!bus.div_start) begin
                        r_state <= IDLE;
                    end else begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random divisions checked against an arithmetic model
module tb_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    div_unit_if #(.DATA_WIDTH(32)) bus ();
    div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    function automatic logic [31:0] mag(input bit s, input logic [31:0] v);
        return (s && v[31]) ? 32'd0 - v : v;
    endfunction

    function automatic int exp_latency(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        return (b == 32'd0 || mag(s, a) < mag(s, b)) ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    task automatic run_div(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
        int n;
        bit seen;
        logic [63:0] exp;
        exp = model(s, a, b);
        @(negedge clk);
        bus.div_signed = s;
        bus.div_data1 = a;
        bus.div_data2 = b;
        bus.div_start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus.div_done;
            if (n == 1) begin
                bus.div_data1 = $urandom;
                bus.div_data2 = $urandom;
                bus.div_signed = ~s;
            end
        end
        check({tag, " done"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(n), 64'(exp_latency(s, a, b)));
        check({tag, " result"}, bus.div_result, exp);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(bus.div_done), 64'd0);
        bus.div_start = 1'b0;
        last_res = exp;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit any;
        any = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            any = any | bus.div_done;
        end
        check({tag, " no_done"}, 64'(any), 64'd0);
    endtask

    initial begin
        bit s;
        logic [31:0] a, b;
        int mode;
        bus.flush = 1'b0;
        bus.div_start = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_data1 = '0;
        bus.div_data2 = '0;
        repeat (3) @(negedge clk);
        check("reset result", bus.div_result, 64'd0);
        check("reset done", 64'(bus.div_done), 64'd0);
        rst_n = 1'b1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7);
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("u-7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_div("udiv0", 1'b0, 32'h1234_5678, 32'd0);
        run_div("sdiv0neg", 1'b1, 32'hFFFF_FF00, 32'd0);
        run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("ssmall", 1'b1, 32'hFFFF_FFFD, 32'd10);
        run_div("snegneg", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF6);
        run_div("s5_-3", 1'b1, 32'd5, 32'hFFFF_FFFD);

        @(negedge clk);
        bus.div_signed = 1'b0;
        bus.div_data1 = 32'd1000;
        bus.div_data2 = 32'd3;
        bus.div_start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.div_start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        watch_no_done("flush", 40);
        check("flush keeps result", bus.div_result, last_res);
        run_div("u9_3", 1'b0, 32'd9, 32'd3);

        @(negedge clk);
        bus.div_data1 = 32'd77777;
        bus.div_data2 = 32'd5;
        bus.div_start = 1'b1;
        repeat (15) @(negedge clk);
        bus.div_start = 1'b0;
        watch_no_done("withdraw", 40);

        @(negedge clk);
        bus.div_data1 = 32'hFFFF_FFFF;
        bus.div_data2 = 32'h10;
        bus.div_start = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset result", bus.div_result, 64'd0);
        check("async reset done", 64'(bus.div_done), 64'd0);
        bus.div_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("post_reset", 40);
        run_div("uFFFFFFFF_10", 1'b0, 32'hFFFF_FFFF, 32'h10);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            a = $urandom;
            b = (mode == 0) ? 32'($urandom) :
                (mode == 1) ? 32'($urandom_range(1, 255)) :
                (mode == 2) ? 32'd0 : 32'($urandom);
            if (mode == 3) a = 32'($urandom_range(0, 100));
            run_div($sformatf("rnd%0d", i), s, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
